jstk2_spi_poller: RTL
=====================

Name: jstk2_spi_poller

Overview:
- SPI master engine between the myJSTK2 AXI4-Lite register slave and the PmodJSTK2 pins.
- Periodically runs 5-byte JSTK2 frames: command plus LED RGB out, X/Y/button status in.
- Latches decoded joystick data for the register file.
- Consumes LED colour and enable controls written over AXI.

Parameters:
- CLK_DIV, 50, S_AXI_ACLK cycles per SCLK half-period (100 MHz -> 1 MHz SCLK); must be >=2
- SS_SETUP, 1500, cycles SS_n held low before first SCLK edge (15 us)
- BYTE_GAP, 1000, idle cycles between bytes with SS_n low (10 us)
- POLL_PERIOD, 1000000, cycles from start of one frame to start of next in auto mode (10 ms)

Ports:
- S_AXI_ACLK  in  1  system clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- enable  in  1  auto polling enable (level)
- start  in  1  one-cycle single-frame request, honoured only in IDLE
- led_set  in  1  1: command 0x84 (set LED); 0: command 0xC0 (read only)
- led_r, led_g, led_b  in  8 each  LED colour bytes
- spi_miso  in  1  from Pmod; pre-synchronised externally
- spi_sclk  out  1  SPI clock, mode 0, idle low
- spi_mosi  out  1  MSB first
- spi_ss_n  out  1  active-low select
- x_pos  out  10  joystick X, 0..1023
- y_pos  out  10  joystick Y, 0..1023
- btn_joy  out  1  button byte bit0
- btn_trig  out  1  button byte bit1
- data_valid  out  1  one-cycle pulse when new X/Y/buttons latch
- busy  out  1  high from leaving IDLE until return to IDLE
- frame_cnt  out  16  completed-frame counter (optional feature)

Behaviour:
- Reset (async assert, sync release): spi_sclk=0, spi_mosi=0, spi_ss_n=1, x_pos=512, y_pos=512, buttons=0, data_valid=0, busy=0, frame_cnt=0, FSM=IDLE, period counter=0.
- Period counter free-runs while enable=1. It wraps at POLL_PERIOD-1, raising an internal tick; it clears when enable=0.
- IDLE: start or tick loads a 5-byte TX buffer {cmd, R, G, B, 0x00}, with cmd = led_set ? 0x84 : 0xC0. The 40-bit buffer is sampled in this cycle and not re-sampled mid-frame. Next state SETUP with ss_n=0 and busy=1.
- start and tick in the same cycle: exactly one frame.
- start while not IDLE: ignored, no queuing. A tick while not IDLE is dropped.
- SETUP: wait SS_SETUP cycles, then SHIFT, bit index 7, byte index 0.
- SHIFT, per bit:
  - mosi is driven at half-period start with SCLK low.
  - SCLK rises after CLK_DIV cycles, and miso is sampled on that rising edge.
  - SCLK falls after another CLK_DIV cycles.
  - After bit 0's falling edge: if byte index <4, go to GAP; else go to DONE.
- GAP: SCLK low for BYTE_GAP cycles, byte index +1, back to SHIFT.
- DONE: ss_n=1. Next cycle:
  - latch x_pos = {rx1[1:0], rx0}, y_pos = {rx3[1:0], rx2}, btn_joy = rx4[0], btn_trig = rx4[1].
  - pulse data_valid for 1 cycle, increment frame_cnt (wraps 0xFFFF->0).
  - return to IDLE with busy=0.
- Outputs hold between frames. enable falling mid-frame does not abort the frame.
- Frame length in cycles: 1 (IDLE) + SS_SETUP + 40*2*CLK_DIV + 4*BYTE_GAP + 2.
- POLL_PERIOD smaller than frame length: the dropped-tick rule applies, and no error is flagged.
- Reset asserted mid-frame: immediate return to reset values with ss_n=1. A partial frame is never latched.

Optional Feature:
- Macro JSTK2_FRAME_CNT_EN.
- Defined: frame_cnt is implemented as above.
- Undefined: frame_cnt is tied to 16'h0000 with no counter flops. All other behaviour is identical.

Test Plan:
- Reset / idle levels (CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3): reset with no stimulus -> ss_n=1, sclk=0, x_pos=y_pos=512, busy=0, no data_valid for 200 cycles with enable=0.
- LED-set frame: start with led_set=1, R=0x12, G=0x34, B=0x56; slave model returns 0xFF,0x02,0x10,0x01,0x03.
  - MOSI bytes are 0x84,0x12,0x34,0x56,0x00 on rising edges.
  - Afterwards x_pos=0x2FF, y_pos=0x110, btn_joy=1, btn_trig=1, one data_valid pulse.
  - Frame length is 1+4+160+12+2 cycles.
- Read-only frame: led_set=0, slave returns 0x00,0x00,0xFF,0x03,0x00.
  - First MOSI byte is 0xC0.
  - Afterwards x_pos=0, y_pos=1023, buttons=0.
- Auto poll (POLL_PERIOD=400, enable=1 for 2000 cycles): exactly 5 data_valid pulses spaced 400 cycles; with the macro, frame_cnt=5.
  - A start pulse mid-frame adds no extra frame.
  - A colour change mid-frame takes effect only on the next frame.
- Reset mid-frame: ARESETN low during byte 2 -> ss_n=1 within the same cycle, x_pos stays 512, no data_valid.
  - After release, the next start yields a normal full frame.

Source files
------------

// File: rtl/jstk2_spi_poller.sv
// SPI master that polls a PmodJSTK2 with 5-byte frames and latches X/Y/button data.
// Optional completed-frame counter enabled by defining JSTK2_FRAME_CNT_EN.
module jstk2_spi_poller #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned SS_SETUP    = 1500,
  parameter int unsigned BYTE_GAP    = 1000,
  parameter int unsigned POLL_PERIOD = 1000000
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        enable,
  input  logic        start,
  input  logic        led_set,
  input  logic [7:0]  led_r,
  input  logic [7:0]  led_g,
  input  logic [7:0]  led_b,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_ss_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        btn_joy,
  output logic        btn_trig,
  output logic        data_valid,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CntMax = (SS_SETUP > BYTE_GAP) ?
                                   ((SS_SETUP > CLK_DIV) ? SS_SETUP : CLK_DIV) :
                                   ((BYTE_GAP > CLK_DIV) ? BYTE_GAP : CLK_DIV);
  localparam int unsigned CntW = $clog2(CntMax);
  localparam int unsigned PerW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PerW-1:0]   pcnt_q;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [39:0]       tx_q, tx_d;
  logic [39:0]       rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              joy_q, joy_d;
  logic              trig_q, trig_d;
  logic              tick;

  assign tick = enable && (pcnt_q == PerW'(POLL_PERIOD - 1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pcnt_q <= '0;
    end else if (!enable || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    joy_d   = joy_q;
    trig_d  = trig_q;
    unique case (state_q)
      StIdle: begin
        if (start || tick) begin
          tx_d    = {(led_set ? 8'h84 : 8'hC0), led_r, led_g, led_b, 8'h00};
          cnt_d   = '0;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SS_SETUP - 1)) begin
          cnt_d   = '0;
          bit_d   = 3'd7;
          byte_d  = 3'd0;
          mosi_d  = tx_q[39];
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[38:0], spi_miso};
          end else begin
            // Falling edge: advance TX so tx_q[39] is always the bit on the wire.
            sclk_d = 1'b0;
            tx_d   = {tx_q[38:0], 1'b0};
            mosi_d = tx_q[38];
            if (bit_q == 3'd0) begin
              bit_d = 3'd7;
              if (byte_q < 3'd4) begin
                state_d = StGap;
              end else begin
                mosi_d  = 1'b0;
                ss_n_d  = 1'b1;
                state_d = StDone;
              end
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(BYTE_GAP - 1)) begin
          cnt_d   = '0;
          byte_d  = byte_q + 3'd1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        x_d     = {rx_q[25:24], rx_q[39:32]};
        y_d     = {rx_q[9:8], rx_q[23:16]};
        joy_d   = rx_q[0];
        trig_d  = rx_q[1];
        dv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      byte_q  <= 3'd0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      x_q     <= 10'd512;
      y_q     <= 10'd512;
      joy_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      joy_q   <= joy_d;
      trig_q  <= trig_d;
    end
  end

`ifdef JSTK2_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      fcnt_q <= '0;
    end else if (state_q == StDone) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_ss_n   = ss_n_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign btn_joy    = joy_q;
  assign btn_trig   = trig_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule
